seq_shifter: RTL
================

Name: seq_shifter

Overview:
- Iterative shifter: one bit position per clock; same shift semantics as the team's combinational 8-bit barrel shifter.
- Operands come in and results go out over valid/ready handshakes.
- Trades latency for area; also serves as a cycle-by-cycle golden partner for the combinational shifter in shared benches.
- Sits between an operand source and a result consumer (e.g. a switch/LED lab harness).

Parameters:
- WIDTH, 8, data width in bits.
- SHW, 3, shift-amount width; must satisfy 2^SHW <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand.
- din  input  WIDTH  data to shift.
- shamt  input  SHW  shift amount, 0..2^SHW-1.
- LR  input  1  direction: 1 = left, 0 = right.
- AL  input  1  right-shift fill: 1 = arithmetic (replicate MSB), 0 = logical (zero). Ignored for left shifts.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- dout  output  WIDTH  shifted result.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM returns to IDLE; any in-flight operation is discarded.
  - in_ready=0 during the reset cycle, 1 from the first cycle after release.
  - out_valid=0, dout=0, internal count=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid&&in_ready at edge T.
  - Capture din into working register, shamt into count, and latch LR/AL.
  - Go to SHIFT.
- SHIFT, each cycle:
  - If count!=0: shift working register by one position and decrement count.
    - Left: {w[WIDTH-2:0],1'b0}.
    - Right logical: {1'b0,w[WIDTH-1:1]}.
    - Right arithmetic: {w[WIDTH-1],w[WIDTH-1:1]}.
  - If count==0: go to DONE; dout = working register.
- Latency: out_valid first high at cycle T+shamt+1 after the accept edge. shamt=0 gives a 1-cycle pass-through (dout=din).
- DONE:
  - dout and out_valid held stable until out_valid&&out_ready.
  - On that edge: go to IDLE, drop out_valid, keep dout at its last value.
- Throughput: one operation in flight; next accept no earlier than the cycle after the result handshake. No in/out overlap.
- Input changes:
  - din/shamt/LR/AL changes while not in IDLE have no effect.
  - in_valid while busy is ignored; no queueing. The source must hold the request until in_ready.
- Boundary cases:
  - shamt=WIDTH-1 right arithmetic with MSB=1 yields all ones.
  - Left with shamt=WIDTH-1 leaves only the old bit 0 in the MSB.
- Reset asserted in SHIFT or DONE: abort; no out_valid pulse for the aborted operation.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: SEQ_SHIFTER_ROTATE_EN.
- Defined:
  - Extra input port rot (1 bit), latched at accept.
  - rot=1 makes each step a rotate: left {w[WIDTH-2:0],w[WIDTH-1]}, right {w[0],w[WIDTH-1:1]}; AL ignored.
  - rot=0 behaves exactly as the non-rotate block.
  - Latency unchanged.
- Not defined: no rot port; behaviour exactly as Behaviour above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, dout=8'h00.
- din=8'hB4, shamt=3, LR=0, AL=1, out_ready=1 -> out_valid rises 4 cycles after accept, dout=8'hF6; same with AL=0 -> dout=8'h16.
- din=8'hB4, shamt=2, LR=1 -> dout=8'hD0 after 3 cycles. shamt=0 -> dout=8'hB4 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles in DONE -> dout/out_valid stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> one-cycle handshake, then IDLE.
- Reset mid-SHIFT (shamt=7, rst_n low on 3rd shift cycle) -> IDLE next cycle, no out_valid for the aborted op; a subsequent op (8'h81, shamt=1, LR=1) gives dout=8'h02.
- With SEQ_SHIFTER_ROTATE_EN: din=8'h81, shamt=1, LR=1, rot=1 -> dout=8'h03; LR=0 -> dout=8'hC0.

Source files
------------

// File: rtl/seq_shifter.sv
// Iterative shifter, one bit per clock; result after shamt+1 cycles, held until out_ready.
// One op in flight, in_ready only in IDLE. Define SEQ_SHIFTER_ROTATE_EN to add the rot input.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             LR,
  input  logic             AL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
`ifdef SEQ_SHIFTER_ROTATE_EN
  ,
  input  logic             rot
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] C_ONE = SHW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_dout;
  logic [SHW-1:0]   r_count;
  logic             r_lr;
  logic             r_al;
  logic             w_rot;
  logic             w_accept;
  logic             w_step_en;
  logic             w_finish;
  logic             w_fill_r;
  logic             w_fill_l;
  logic [WIDTH-1:0] w_step;

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic r_rot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rot <= 1'b0;
    end else if (w_accept) begin
      r_rot <= rot;
    end
  end

  assign w_rot = r_rot;
`else
  assign w_rot = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_step_en   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by rst_n so in_ready reads 0 during the reset cycle itself.
        in_ready = rst_n;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_count != '0) begin
          w_step_en = 1'b1;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fill bit entering the vacated end: rotate wins over arithmetic/logical.
  always_comb begin
    w_fill_l = w_rot ? r_work[WIDTH-1] : 1'b0;
    w_fill_r = w_rot ? r_work[0] : (r_al & r_work[WIDTH-1]);
    if (r_lr) begin
      w_step = {r_work[WIDTH-2:0], w_fill_l};
    end else begin
      w_step = {w_fill_r, r_work[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_count <= '0;
      r_lr    <= 1'b0;
      r_al    <= 1'b0;
      r_dout  <= '0;
    end else begin
      if (w_accept) begin
        r_work  <= din;
        r_count <= shamt;
        r_lr    <= LR;
        r_al    <= AL;
      end else if (w_step_en) begin
        r_work  <= w_step;
        r_count <= r_count - C_ONE;
      end
      if (w_finish) begin
        r_dout <= r_work;
      end
    end
  end

  assign dout = r_dout;

endmodule
